// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the serial pattern detector controller.
package seq_detect_ctrl_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A configuration is usable only with a non-empty, in-range length and a non-zero target.
  function automatic logic cfg_is_legal(input int len, input int max_len, input logic target_nz);
    return (len >= 1) && (len <= max_len) && target_nz;
  endfunction

endpackage

// File: rtl/seq_detect_shift_reg.sv
// History shift register, fill counter and length-masked compare against the stored pattern.
module seq_detect_shift_reg #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               filled,
  output logic               match
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

  // filled/match describe the history as it will be after this cycle's shift,
  // so the registered detected pulse lands one cycle after the completing bit.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], bit_in};
    fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    filled = shift_en && (fill_inc >= len);
    match  = filled && (((hist_shift ^ pattern) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: config handshake, arm/run FSM and match counting toward a target.
// Define SEQ_DETECT_CTRL_NONOVERLAP_EN to make each non-final match restart with fresh bits.
//
// state | meaning
// IDLE  | not armed; config accepted, start arms if configured
// ARMED | collecting the first len bits after arm (or after a non-overlap match)
// RUN   | history full; every valid bit is compared
// DONE  | target reached; bits ignored, config and start accepted
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic                         start,
  input  logic                         bit_valid,
  input  logic                         new_bit,
  output logic                         detected,
  output logic [CNT_W-1:0]             match_count,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d, count_inc;
  logic               configured_q, configured_d;
  logic               detected_q, detected_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               hs, cfg_ok, armable;
  logic               sr_clr, sr_shift, sr_filled, sr_match;

  assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy        = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign detected    = detected_q;
  assign match_count = match_count_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

  seq_detect_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .bit_in   (new_bit),
    .pattern  (pattern_q),
    .len      (len_q),
    .filled   (sr_filled),
    .match    (sr_match)
  );

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    len_d         = len_q;
    target_d      = target_q;
    match_count_d = match_count_q;
    configured_d  = configured_q;
    detected_d    = 1'b0;
    done_d        = done_q;
    cfg_err_d     = cfg_err_q;
    sr_clr        = 1'b0;
    sr_shift      = 1'b0;
    count_inc     = match_count_q + CNT_W'(1);

    hs     = cfg_valid && cfg_ready;
    cfg_ok = cfg_is_legal(int'(cfg_len), MAX_LEN, cfg_target != '0);
    if (hs) begin
      configured_d = cfg_ok;
      cfg_err_d    = !cfg_ok;
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        target_d  = cfg_target;
      end
    end
    // A same-cycle handshake decides whether start may arm.
    armable = hs ? cfg_ok : configured_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && armable) begin
          state_d       = ST_ARMED;
          sr_clr        = 1'b1;
          match_count_d = '0;
          done_d        = 1'b0;
        end
      end
      ST_ARMED, ST_RUN: begin
        if (bit_valid) begin
          sr_shift = 1'b1;
          if (sr_match) begin
            detected_d    = 1'b1;
            match_count_d = count_inc;
            if (count_inc == target_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
              sr_clr  = 1'b1;
              state_d = ST_ARMED;
`else
              state_d = ST_RUN;
`endif
            end
          end else if (sr_filled) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pattern_q     <= '0;
      len_q         <= '0;
      target_q      <= '0;
      match_count_q <= '0;
      configured_q  <= 1'b0;
      detected_q    <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      len_q         <= len_d;
      target_q      <= target_d;
      match_count_q <= match_count_d;
      configured_q  <= configured_d;
      detected_q    <= detected_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

endmodule
